// File: rtl/mux_scan_capture.sv
// Scan sequencer and deserializer for an N-bit select mux.
// Walks sel through 0..2**N-1, samples mux_out once per code, and
// presents the rebuilt 2**N-bit word on a valid/ready handshake.
module mux_scan_capture #(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mux_out,
    output logic [N-1:0]    sel,
    output logic            busy,
    output logic            valid,
    input  logic            ready,
    output logic [2**N-1:0] data
);

    localparam int unsigned W = 2**N;
    localparam logic [N-1:0] SelLast = '1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   sel_q,   sel_d;
    logic           busy_q,  busy_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   data_q,  data_d;

    // State and registered outputs; reset drops any partial capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Next-state: scan sequencing, bit capture and handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;

        case (state_q)
            StIdle: begin
                sel_d = '0;
                if (start) begin
                    state_d = StScan;
                    busy_d  = 1'b1;
                end
            end

            StScan: begin
                // mux_out has settled for the code presented this cycle.
                data_d[sel_q] = mux_out;
                if (sel_q == SelLast) begin
                    sel_d   = '0;
                    state_d = StHold;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    sel_d = sel_q + N'(1);
                end
            end

            StHold: begin
                // start only matters on the handshake edge; it is not latched.
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (start) begin
                        state_d = StScan;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                sel_d   = '0;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign sel   = sel_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture at N=4, N=2 and N=5.
// Each instance is paired with a behavioural mux: mux_out = vec[sel].
module tb_mux_scan_capture;

    logic clk;
    logic rst;

    logic        start4, ready4, mux4, busy4, valid4;
    logic [3:0]  sel4;
    logic [15:0] vec4, data4;

    logic        start2, ready2, mux2, busy2, valid2;
    logic [1:0]  sel2;
    logic [3:0]  vec2, data2;

    logic        start5, ready5, mux5, busy5, valid5;
    logic [4:0]  sel5;
    logic [31:0] vec5, data5;

    int total;
    int bad;

    assign mux4 = vec4[sel4];
    assign mux2 = vec2[sel2];
    assign mux5 = vec5[sel5];

    mux_scan_capture #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mux_out(mux4), .sel(sel4),
        .busy(busy4), .valid(valid4), .ready(ready4), .data(data4)
    );

    mux_scan_capture #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mux_out(mux2), .sel(sel2),
        .busy(busy2), .valid(valid2), .ready(ready2), .data(data2)
    );

    mux_scan_capture #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .mux_out(mux5), .sel(sel5),
        .busy(busy5), .valid(valid5), .ready(ready5), .data(data5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (sel4 !== 4'd0 || busy4 !== 1'b0 || valid4 !== 1'b0 || data4 !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: sel=%h busy=%b valid=%b data=%h want 0/0/0/0000",
                     sel4, busy4, valid4, data4);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sel4 !== 4'd0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: sel=%h busy=%b want 0/0", sel4, busy4);
        end
    endtask

    task automatic test_basic;
        vec4   = 16'hA607;
        ready4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (sel4 !== 4'(k) || busy4 !== 1'b1 || valid4 !== 1'b0) begin
                bad++;
                $display("FAIL basic_scan k=%0d: sel=%h busy=%b valid=%b want %h/1/0",
                         k, sel4, busy4, valid4, 4'(k));
            end
            @(negedge clk);
        end
        total++;
        if (valid4 !== 1'b1 || data4 !== 16'hA607 || busy4 !== 1'b0 || sel4 !== 4'd0) begin
            bad++;
            $display("FAIL basic_word: valid=%b data=%h busy=%b sel=%h want 1/a607/0/0",
                     valid4, data4, busy4, sel4);
        end
        @(negedge clk);
        total++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0 || sel4 !== 4'd0 || data4 !== 16'hA607) begin
            bad++;
            $display("FAIL basic_idle: valid=%b busy=%b sel=%h data=%h want 0/0/0/a607",
                     valid4, busy4, sel4, data4);
        end
    endtask

    task automatic test_backpressure;
        vec4   = 16'hA607;
        ready4 = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (valid4 !== 1'b1 || data4 !== 16'hA607 || busy4 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold i=%0d: valid=%b data=%h busy=%b want 1/a607/0",
                         i, valid4, data4, busy4);
            end
            start4 = (i == 3 || i == 6);
            @(negedge clk);
        end
        start4 = 1'b0;
        ready4 = 1'b1;
        @(negedge clk);
        total++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: valid=%b busy=%b want 0/0", valid4, busy4);
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0) begin
            bad++;
            $display("FAIL bp_start_not_latched: busy=%b valid=%b want 0/0", busy4, valid4);
        end
    endtask

    task automatic test_back_to_back;
        vec4   = 16'hA607;
        ready4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        repeat (16) @(negedge clk);
        total++;
        if (valid4 !== 1'b1 || data4 !== 16'hA607) begin
            bad++;
            $display("FAIL b2b_first: valid=%b data=%h want 1/a607", valid4, data4);
        end
        vec4 = 16'h5A3C;
        @(negedge clk);
        total++;
        if (valid4 !== 1'b0 || busy4 !== 1'b1 || sel4 !== 4'd0) begin
            bad++;
            $display("FAIL b2b_no_bubble: valid=%b busy=%b sel=%h want 0/1/0",
                     valid4, busy4, sel4);
        end
        for (int k = 1; k < 17; k++) begin
            if (k < 16) begin
                total++;
                if (valid4 !== 1'b0 || busy4 !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_scan k=%0d: valid=%b busy=%b want 0/1", k, valid4, busy4);
                end
            end
            @(negedge clk);
        end
        total++;
        if (valid4 !== 1'b1 || data4 !== 16'h5A3C || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: valid=%b data=%h busy=%b want 1/5a3c/0",
                     valid4, data4, busy4);
        end
        start4 = 1'b0;
        @(negedge clk);
        total++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: valid=%b busy=%b want 0/0", valid4, busy4);
        end
    endtask

    task automatic test_reset_mid_scan;
        vec4   = 16'hA607;
        ready4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (7) @(negedge clk);
        total++;
        if (sel4 !== 4'd7) begin
            bad++;
            $display("FAIL midrst_pre: sel=%h want 7", sel4);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sel4 !== 4'd0 || busy4 !== 1'b0 || valid4 !== 1'b0 || data4 !== 16'h0) begin
            bad++;
            $display("FAIL midrst_async: sel=%h busy=%b valid=%b data=%h want 0/0/0/0000",
                     sel4, busy4, valid4, data4);
        end
        @(negedge clk);
        rst = 1'b0;
        vec4   = 16'h5A3C;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (16) @(negedge clk);
        total++;
        if (valid4 !== 1'b1 || data4 !== 16'h5A3C) begin
            bad++;
            $display("FAIL midrst_rescan: valid=%b data=%h want 1/5a3c", valid4, data4);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int extra;
        vec4   = 16'hA607;
        ready4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            start4 = (k == 3 || k == 15);
            total++;
            if (valid4 !== 1'b0 || sel4 !== 4'(k)) begin
                bad++;
                $display("FAIL busy_start k=%0d: valid=%b sel=%h want 0/%h",
                         k, valid4, sel4, 4'(k));
            end
            @(negedge clk);
        end
        start4 = 1'b0;
        total++;
        if (valid4 !== 1'b1 || data4 !== 16'hA607) begin
            bad++;
            $display("FAIL busy_word: valid=%b data=%h want 1/a607", valid4, data4);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid4 === 1'b1 || busy4 === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_single_valid: extra active cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_param_sweep;
        logic [31:0] pats [3];
        vec2   = 4'b1001;
        ready2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (valid2 !== 1'b0 || sel2 !== 2'd3) begin
            bad++;
            $display("FAIL n2_early: valid=%b sel=%h want 0/3", valid2, sel2);
        end
        @(negedge clk);
        total++;
        if (valid2 !== 1'b1 || data2 !== 4'b1001) begin
            bad++;
            $display("FAIL n2_word: valid=%b data=%b want 1/1001", valid2, data2);
        end
        @(negedge clk);

        pats[0] = 32'h0000_0001;
        pats[1] = 32'h0000_2000;
        pats[2] = 32'h8000_0000;
        ready5 = 1'b1;
        for (int p = 0; p < 3; p++) begin
            vec5   = pats[p];
            start5 = 1'b1;
            @(negedge clk);
            start5 = 1'b0;
            repeat (31) @(negedge clk);
            total++;
            if (valid5 !== 1'b0 || sel5 !== 5'd31) begin
                bad++;
                $display("FAIL n5_early p=%0d: valid=%b sel=%h want 0/1f", p, valid5, sel5);
            end
            @(negedge clk);
            total++;
            if (valid5 !== 1'b1 || data5 !== pats[p]) begin
                bad++;
                $display("FAIL n5_word p=%0d: valid=%b data=%h want 1/%h",
                         p, valid5, data5, pats[p]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        start4 = 1'b0;
        ready4 = 1'b0;
        vec4   = '0;
        start2 = 1'b0;
        ready2 = 1'b0;
        vec2   = '0;
        start5 = 1'b0;
        ready5 = 1'b0;
        vec5   = '0;
        rst    = 1'b1;

        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_scan;
        test_start_while_busy;
        test_param_sweep;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
